idu_stage: RTL and testbench

- Registered, handshaked RV32I(+Zicsr subset) decode stage between IFU and EXU of the NPC core.
- Decodes into a compact encoded control bundle (alu_op / class codes) instead of one-hot flags.
- Detects illegal encodings.
- Buffers decoded bundles in a parametrised FIFO, supporting flush and back-pressure.

---
 rtl/idu_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_idu_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_stage.sv
// idu_stage: registered, handshaked RV32I (+ Zicsr subset) decode stage that
// sits between the IFU and the EXU.
//
// Each instruction offered by the IFU is decoded combinationally into a
// compact control bundle. The bundle holds encoded alu_op and class codes, the
// register fields, the sign-extended immediate, the CSR address and an illegal
// flag. The bundle is written into a small FIFO at the push edge. The EXU
// reads the head entry through a valid/ready handshake.
//
// Optional feature: define IDU_RV32M_EN to decode the RV32M multiply/divide
// group (OP with funct7=0x01). When the macro is undefined, those encodings
// are illegal.
//
// Ports:
//   clk, rst         core clock; synchronous active-high reset
//   in_valid/ready   IFU handshake (in_ready = occupancy below DEPTH)
//   in_inst, in_pc   instruction word and its PC
//   flush            drop every buffered entry and any same-cycle push
//   out_valid/ready  EXU handshake on the head entry
//   out_pc           PC of the head entry
//   out_rs1/rs2/rd   register address fields
//   out_imm          sign-extended immediate
//   out_csr          CSR address (SYSTEM only)
//   out_funct3       raw funct3 field
//   out_alu_op       encoded ALU operation
//   out_class        encoded instruction class
//   out_wen          GPR write-back enable
//   out_mem_valid    memory access
//   out_mem_wen      the memory access is a store
//   out_illegal      illegal encoding
//   out_count        current FIFO occupancy
module idu_stage #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_imm,
  output logic [11:0]      out_csr,
  output logic [2:0]       out_funct3,
  output logic [4:0]       out_alu_op,
  output logic [3:0]       out_class,
  output logic             out_wen,
  output logic             out_mem_valid,
  output logic             out_mem_wen,
  output logic             out_illegal,
  output logic [CNT_W-1:0] out_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_PASS = 5'd10;
`ifdef IDU_RV32M_EN
  localparam logic [4:0] ALU_MUL  = 5'd16;
`endif

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_ALU_R   = 4'd1,
    CLS_ALU_I   = 4'd2,
    CLS_LUI     = 4'd3,
    CLS_AUIPC   = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_BRANCH  = 4'd7,
    CLS_JAL     = 4'd8,
    CLS_JALR    = 4'd9,
    CLS_ECALL   = 4'd10,
    CLS_EBREAK  = 4'd11,
    CLS_CSRRW   = 4'd12,
    CLS_CSRRS   = 4'd13
  } class_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [11:0]     csr;
    logic [2:0]      funct3;
    logic [4:0]      alu_op;
    logic [3:0]      cls;
    logic            wen;
    logic            mem_valid;
    logic            mem_wen;
    logic            illegal;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  entry_t     dec;
  entry_t     head;
  class_e     cls;
  logic [4:0] alu;
  logic [31:0] imm;
  logic       legal;
  logic       wen_class;
  logic       push;
  logic       pop;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                  in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                  in_inst[30:21], 1'b0};

  // funct3 selects the base operation for both OP and OP-IMM.
  // alt picks SUB over ADD and SRA over SRL.
  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(DEPTH - 1)) n = '0;
    else                        n = p + PTR_W'(1);
    return n;
  endfunction

  always_comb begin
    legal = 1'b1;
    cls   = CLS_ILLEGAL;
    alu   = ALU_ADD;
    imm   = '0;
    case (opcode)
      OPC_OP: begin
        cls = CLS_ALU_R;
        if (funct7 == 7'h00)
          alu = alu_from_f3(funct3, 1'b0);
        else if (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))
          alu = alu_from_f3(funct3, 1'b1);
`ifdef IDU_RV32M_EN
        else if (funct7 == 7'h01)
          alu = ALU_MUL + {2'b00, funct3};
`endif
        else
          legal = 1'b0;
      end
      OPC_OP_IMM: begin
        // For ADDI-style forms funct7 is part of the immediate.
        // Only the shift forms constrain it.
        cls = CLS_ALU_I;
        imm = imm_i;
        alu = alu_from_f3(funct3, funct3 == 3'b101 && funct7 == 7'h20);
        if (funct3 == 3'b001 && funct7 != 7'h00)
          legal = 1'b0;
        if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)
          legal = 1'b0;
      end
      OPC_LOAD: begin
        cls = CLS_LOAD;
        imm = imm_i;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
          legal = 1'b0;
      end
      OPC_STORE: begin
        cls = CLS_STORE;
        imm = imm_s;
        if (funct3 > 3'b010)
          legal = 1'b0;
      end
      OPC_BRANCH: begin
        cls = CLS_BRANCH;
        alu = ALU_SUB;
        imm = imm_b;
        if (funct3 == 3'b010 || funct3 == 3'b011)
          legal = 1'b0;
      end
      OPC_JAL: begin
        cls = CLS_JAL;
        imm = imm_j;
      end
      OPC_JALR: begin
        cls = CLS_JALR;
        imm = imm_i;
        if (funct3 != 3'b000)
          legal = 1'b0;
      end
      OPC_LUI: begin
        cls = CLS_LUI;
        alu = ALU_PASS;
        imm = imm_u;
      end
      OPC_AUIPC: begin
        cls = CLS_AUIPC;
        imm = imm_u;
      end
      OPC_SYSTEM: begin
        case (funct3)
          3'b000: begin
            if (in_inst == 32'h0000_0073)      cls = CLS_ECALL;
            else if (in_inst == 32'h0010_0073) cls = CLS_EBREAK;
            else                               legal = 1'b0;
          end
          3'b001:  cls = CLS_CSRRW;
          3'b010:  cls = CLS_CSRRS;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    // An illegal encoding keeps its raw fields but carries no operation.
    if (!legal) begin
      cls = CLS_ILLEGAL;
      alu = ALU_ADD;
    end

    case (cls)
      CLS_ALU_R, CLS_ALU_I, CLS_LUI, CLS_AUIPC, CLS_LOAD,
      CLS_JAL, CLS_JALR, CLS_CSRRW, CLS_CSRRS: wen_class = 1'b1;
      default:                                  wen_class = 1'b0;
    endcase

    dec           = '0;
    dec.pc        = in_pc;
    dec.rs1       = in_inst[19:15];
    dec.rs2       = in_inst[24:20];
    dec.rd        = in_inst[11:7];
    dec.imm       = imm;
    dec.csr       = (opcode == OPC_SYSTEM) ? in_inst[31:20] : 12'h000;
    dec.funct3    = funct3;
    dec.alu_op    = alu;
    dec.cls       = cls;
    dec.wen       = wen_class && (in_inst[11:7] != 5'd0);
    dec.mem_valid = (cls == CLS_LOAD) || (cls == CLS_STORE);
    dec.mem_wen   = (cls == CLS_STORE);
    dec.illegal   = !legal;
  end

  // in_ready depends only on occupancy, so a pop while full never lets a
  // push through in the same cycle.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // FIFO state. Reset also clears storage so every output reads zero.
  // Flush only rewinds the pointers, which hides whatever is stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  assign head          = mem[rd_ptr];
  assign out_pc        = head.pc;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_rd        = head.rd;
  assign out_imm       = head.imm;
  assign out_csr       = head.csr;
  assign out_funct3    = head.funct3;
  assign out_alu_op    = head.alu_op;
  assign out_class     = head.cls;
  assign out_wen       = head.wen;
  assign out_mem_valid = head.mem_valid;
  assign out_mem_wen   = head.mem_wen;
  assign out_illegal   = head.illegal;
  assign out_count     = count;

endmodule

// File: tb/tb_idu_stage.sv
// tb_idu_stage: directed bench for idu_stage (default parameters, DEPTH=2).
// A table of single-instruction decode vectors is applied in a loop.
// Hand-written sequences cover these multi-cycle cases:
//   - reset
//   - latency
//   - back-pressure and ordering
//   - flush
//   - reset with buffered entries
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic [11:0] out_csr;
  logic [2:0]  out_funct3;
  logic [4:0]  out_alu_op;
  logic [3:0]  out_class;
  logic        out_wen, out_mem_valid, out_mem_wen, out_illegal;
  logic [1:0]  out_count;

  int compared = 0;
  int mismatched = 0;

  idu_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_csr(out_csr), .out_funct3(out_funct3),
    .out_alu_op(out_alu_op), .out_class(out_class), .out_wen(out_wen),
    .out_mem_valid(out_mem_valid), .out_mem_wen(out_mem_wen),
    .out_illegal(out_illegal), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  cls;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] csr;
    logic        wen, mv, mw, ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(logic [31:0] inst, logic [3:0] cls, logic [4:0] alu,
                                 logic [31:0] imm, logic [4:0] rd, logic [4:0] rs1,
                                 logic [4:0] rs2, logic [2:0] f3, logic [11:0] csr,
                                 logic wen, logic mv, logic mw, logic ill);
    vec_t v;
    v.inst = inst; v.cls = cls; v.alu = alu; v.imm = imm;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.csr = csr;
    v.wen = wen; v.mv = mv; v.mw = mw; v.ill = ill;
    return v;
  endfunction

  // Advance one clock: inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Push one vector into an empty stage, check the decoded head, then pop it.
  task automatic applyStimulus(input int idx, input vec_t v);
    string p;
    logic [31:0] pc;
    p  = $sformatf("v%0d", idx);
    pc = 32'h0000_1000 + 32'(idx * 4);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = v.inst;
    in_pc     = pc;
    tick();
    in_valid = 1'b0;
    checkOutput({p, ".valid"}, 32'(out_valid), 32'd1);
    checkOutput({p, ".pc"},    out_pc, pc);
    checkOutput({p, ".class"}, 32'(out_class), 32'(v.cls));
    checkOutput({p, ".alu"},   32'(out_alu_op), 32'(v.alu));
    checkOutput({p, ".imm"},   out_imm, v.imm);
    checkOutput({p, ".rd"},    32'(out_rd), 32'(v.rd));
    checkOutput({p, ".rs1"},   32'(out_rs1), 32'(v.rs1));
    checkOutput({p, ".rs2"},   32'(out_rs2), 32'(v.rs2));
    checkOutput({p, ".f3"},    32'(out_funct3), 32'(v.f3));
    checkOutput({p, ".csr"},   32'(out_csr), 32'(v.csr));
    checkOutput({p, ".wen"},   32'(out_wen), 32'(v.wen));
    checkOutput({p, ".memv"},  32'(out_mem_valid), 32'(v.mv));
    checkOutput({p, ".memw"},  32'(out_mem_wen), 32'(v.mw));
    checkOutput({p, ".ill"},   32'(out_illegal), 32'(v.ill));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({p, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    //          inst          cls alu  imm           rd  rs1 rs2 f3 csr     wen mv mw ill
    vecs.push_back(mkVec(32'h00500093, 2, 0,  32'h5,        1,  0,  5,  0, 12'h0,   1, 0, 0, 0));
    vecs.push_back(mkVec(32'h002081B3, 1, 0,  32'h0,        3,  1,  2,  0, 12'h0,   1, 0, 0, 0));
    vecs.push_back(mkVec(32'h00812283, 5, 0,  32'h8,        5,  2,  8,  2, 12'h0,   1, 1, 0, 0));
    vecs.push_back(mkVec(32'h00512223, 6, 0,  32'h4,        4,  2,  5,  2, 12'h0,   0, 1, 1, 0));
    vecs.push_back(mkVec(32'hFFFFFFFF, 0, 0,  32'h0,        31, 31, 31, 7, 12'h0,   0, 0, 0, 1));
    vecs.push_back(mkVec(32'h00100073, 11, 0, 32'h0,        0,  0,  1,  0, 12'h001, 0, 0, 0, 0));
    vecs.push_back(mkVec(32'h00000073, 10, 0, 32'h0,        0,  0,  0,  0, 12'h0,   0, 0, 0, 0));
`ifdef IDU_RV32M_EN
    vecs.push_back(mkVec(32'h023100B3, 1, 16, 32'h0,        1,  2,  3,  0, 12'h0,   1, 0, 0, 0));
`else
    vecs.push_back(mkVec(32'h023100B3, 0, 0,  32'h0,        1,  2,  3,  0, 12'h0,   0, 0, 0, 1));
`endif
    vecs.push_back(mkVec(32'h00000013, 2, 0,  32'h0,        0,  0,  0,  0, 12'h0,   0, 0, 0, 0));
    vecs.push_back(mkVec(32'h123452B7, 3, 10, 32'h12345000, 5,  8,  3,  5, 12'h0,   1, 0, 0, 0));
    vecs.push_back(mkVec(32'hFFFFF317, 4, 0,  32'hFFFFF000, 6,  31, 31, 7, 12'h0,   1, 0, 0, 0));
    vecs.push_back(mkVec(32'hFFDFF0EF, 8, 0,  32'hFFFFFFFC, 1,  31, 29, 7, 12'h0,   1, 0, 0, 0));
    vecs.push_back(mkVec(32'h00008067, 9, 0,  32'h0,        0,  1,  0,  0, 12'h0,   0, 0, 0, 0));
    vecs.push_back(mkVec(32'hFE208CE3, 7, 1,  32'hFFFFFFF8, 25, 1,  2,  0, 12'h0,   0, 0, 0, 0));
    vecs.push_back(mkVec(32'h305110F3, 12, 0, 32'h0,        1,  2,  5,  1, 12'h305, 1, 0, 0, 0));
    vecs.push_back(mkVec(32'h300021F3, 13, 0, 32'h0,        3,  0,  0,  2, 12'h300, 1, 0, 0, 0));
    vecs.push_back(mkVec(32'h40628233, 1, 1,  32'h0,        4,  5,  6,  0, 12'h0,   1, 0, 0, 0));
    vecs.push_back(mkVec(32'h40345393, 2, 7,  32'h403,      7,  8,  3,  5, 12'h0,   1, 0, 0, 0));
    vecs.push_back(mkVec(32'h0010D093, 2, 6,  32'h1,        1,  1,  1,  5, 12'h0,   1, 0, 0, 0));
    vecs.push_back(mkVec(32'h007372B3, 1, 9,  32'h0,        5,  6,  7,  7, 12'h0,   1, 0, 0, 0));
    vecs.push_back(mkVec(32'hFFF1B113, 2, 4,  32'hFFFFFFFF, 2,  3,  31, 3, 12'h0,   1, 0, 0, 0));
    vecs.push_back(mkVec(32'h40109093, 0, 0,  32'h401,      1,  1,  1,  1, 12'h0,   0, 0, 0, 1));
    vecs.push_back(mkVec(32'h00013083, 0, 0,  32'h0,        1,  2,  0,  3, 12'h0,   0, 0, 0, 1));
    vecs.push_back(mkVec(32'h00002063, 0, 0,  32'h0,        0,  0,  0,  2, 12'h0,   0, 0, 0, 1));
    vecs.push_back(mkVec(32'h00200073, 0, 0,  32'h0,        0,  0,  2,  0, 12'h002, 0, 0, 0, 1));
    vecs.push_back(mkVec(32'h40001033, 0, 0,  32'h0,        0,  0,  0,  1, 12'h0,   0, 0, 0, 1));

    // Reset state.
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst.valid", 32'(out_valid), 32'd0);
    checkOutput("rst.count", 32'(out_count), 32'd0);
    checkOutput("rst.ready", 32'(in_ready), 32'd1);

    // One-cycle latency with out_ready held high.
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h100; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("lat.valid", 32'(out_valid), 32'd1);
    checkOutput("lat.class", 32'(out_class), 32'd2);
    checkOutput("lat.alu",   32'(out_alu_op), 32'd0);
    checkOutput("lat.rd",    32'(out_rd), 32'd1);
    checkOutput("lat.rs1",   32'(out_rs1), 32'd0);
    checkOutput("lat.imm",   out_imm, 32'd5);
    checkOutput("lat.wen",   32'(out_wen), 32'd1);
    tick();
    checkOutput("lat.popped", 32'(out_valid), 32'd0);

    // Back-pressure: two entries fill the stage and the third waits at the IFU.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h200;
    tick();
    in_inst = 32'h00812283; in_pc = 32'h204;
    tick();
    checkOutput("bp.ready0", 32'(in_ready), 32'd0);
    checkOutput("bp.count2", 32'(out_count), 32'd2);
    checkOutput("bp.add.class", 32'(out_class), 32'd1);
    checkOutput("bp.add.rd", 32'(out_rd), 32'd3);
    in_inst = 32'h00512223; in_pc = 32'h208;
    tick();
    checkOutput("bp.held.count", 32'(out_count), 32'd2);
    checkOutput("bp.held.pc", out_pc, 32'h200);
    out_ready = 1'b1;
    tick();
    checkOutput("bp.lw.class", 32'(out_class), 32'd5);
    checkOutput("bp.lw.imm", out_imm, 32'd8);
    checkOutput("bp.lw.memv", 32'(out_mem_valid), 32'd1);
    checkOutput("bp.lw.count", 32'(out_count), 32'd1);
    checkOutput("bp.ready1", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("bp.sw.class", 32'(out_class), 32'd6);
    checkOutput("bp.sw.imm", out_imm, 32'd4);
    checkOutput("bp.sw.memw", 32'(out_mem_wen), 32'd1);
    checkOutput("bp.sw.wen", 32'(out_wen), 32'd0);
    checkOutput("bp.sw.count", 32'(out_count), 32'd1);
    checkOutput("bp.sw.pc", out_pc, 32'h208);
    tick();
    checkOutput("bp.empty", 32'(out_valid), 32'd0);

    // Flush with non-zero read pointer and a full stage.
    in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h300;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100073; in_pc = 32'h304;
    tick();
    in_inst = 32'h123452B7; in_pc = 32'h308;
    tick();
    checkOutput("fl.full", 32'(out_count), 32'd2);
    flush = 1'b1; in_inst = 32'hFFDFF0EF; in_pc = 32'h30C;
    tick();
    checkOutput("fl.valid", 32'(out_valid), 32'd0);
    checkOutput("fl.count", 32'(out_count), 32'd0);
    flush = 1'b0; in_inst = 32'h00000073; in_pc = 32'h310;
    tick();
    in_valid = 1'b0;
    checkOutput("fl.after.count", 32'(out_count), 32'd1);
    checkOutput("fl.after.class", 32'(out_class), 32'd10);
    checkOutput("fl.after.pc", out_pc, 32'h310);
    // Flush with room available must still drop the same-cycle push.
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h007372B3; in_pc = 32'h314;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("fl.drop.count", 32'(out_count), 32'd0);
    tick();
    checkOutput("fl.drop.valid", 32'(out_valid), 32'd0);

    // Reset with buffered entries clears every output.
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h400;
    tick();
    in_inst = 32'h123452B7; in_pc = 32'h404;
    tick();
    rst = 1'b1; in_inst = 32'hFFDFF0EF; in_pc = 32'h408;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checkOutput("rst2.valid", 32'(out_valid), 32'd0);
    checkOutput("rst2.count", 32'(out_count), 32'd0);
    checkOutput("rst2.pc",    out_pc, 32'd0);
    checkOutput("rst2.imm",   out_imm, 32'd0);
    checkOutput("rst2.regs",  32'({out_rs1, out_rs2, out_rd}), 32'd0);
    checkOutput("rst2.csr",   32'(out_csr), 32'd0);
    checkOutput("rst2.ctl",   32'({out_funct3, out_alu_op, out_class}), 32'd0);
    checkOutput("rst2.flags", 32'({out_wen, out_mem_valid, out_mem_wen, out_illegal}), 32'd0);

    // Table-driven decode vectors.
    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
